vectoring_cordic: RTL and testbench

Iterative vectoring-mode CORDIC. It is the inverse companion of `rotational_cordic`: given a signed Cartesian vector (x, y), it returns the vector's scaled magnitude and its phase angle. It sits beside the rotator in the same datapath and uses the same `start` launch style. It adds a `busy`/`done` handshake so that a controller can sequence conversions back to back.

---
 rtl/vectoring_cordic_if.sv | 20 ++
 rtl/vectoring_cordic.sv | 144 ++++++++++++++
 tb/tb_vectoring_cordic.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vectoring_cordic_if.sv
// Handshake/data bundle for the vectoring CORDIC.
//   start  : launch request (sampled only while the converter is idle)
//   x, y   : signed 16-bit Cartesian input, captured on the accept edge
//   xprime : unsigned 17-bit scaled magnitude (CORDIC gain ~1.6468 left in)
//   theta  : signed 16-bit binary angle, 2^16 = 360 degrees
//   busy   : high from the accept edge until done drops
//   done   : one-cycle pulse when xprime/theta are updated
// master = controller side, slave = converter side.
interface vectoring_cordic_if;
    logic               start;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic        [16:0] xprime;
    logic signed [15:0] theta;
    logic               busy;
    logic               done;

    modport master (output start, x, y, input xprime, theta, busy, done);
    modport slave  (input start, x, y, output xprime, theta, busy, done);
endinterface

// File: rtl/vectoring_cordic.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (K*|v|, atan2(y, x)).
// One micro-rotation per clock after a quadrant pre-rotation that brings
// the vector into the right half plane.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset
//   bus   : vectoring_cordic_if slave (start/x/y in, xprime/theta/busy/done out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; clears done/busy from the previous run
// ITER  | one micro-rotation per clock, iter = 0 .. ITERATIONS-1
// DONE  | register xprime/theta, pulse done, back to IDLE
module vectoring_cordic #(
    parameter int ITERATIONS = 14
) (
    input  logic clk,
    input  logic reset,
    vectoring_cordic_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

    state_t             state;
    logic signed [17:0] x_r;
    logic signed [17:0] y_r;
    logic signed [15:0] z_r;
    logic        [3:0]  iter;
    logic               zero_vec;

    logic signed [17:0] x_in;
    logic signed [17:0] y_in;
    logic signed [17:0] pre_x;
    logic signed [17:0] pre_y;
    logic signed [15:0] pre_z;
    logic signed [17:0] x_shift;
    logic signed [17:0] y_shift;
    logic signed [15:0] atan_i;
    logic               d_pos;

    function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'sd8192;
            4'd1:    return 16'sd4836;
            4'd2:    return 16'sd2555;
            4'd3:    return 16'sd1297;
            4'd4:    return 16'sd651;
            4'd5:    return 16'sd326;
            4'd6:    return 16'sd163;
            4'd7:    return 16'sd81;
            4'd8:    return 16'sd41;
            4'd9:    return 16'sd20;
            4'd10:   return 16'sd10;
            4'd11:   return 16'sd5;
            4'd12:   return 16'sd3;
            4'd13:   return 16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

    // Left-half-plane inputs are turned by -/+90 degrees so the iterations
    // only ever need to cover +/-99.9 degrees; 18 bits hold -(-32768).
    always_comb begin
        x_in  = {{2{bus.x[15]}}, bus.x};
        y_in  = {{2{bus.y[15]}}, bus.y};
        pre_x = x_in;
        pre_y = y_in;
        pre_z = 16'sd0;
        if (bus.x[15]) begin
            if (!bus.y[15]) begin
                pre_x = y_in;
                pre_y = -x_in;
                pre_z = 16'sd16384;
            end else begin
                pre_x = -y_in;
                pre_y = x_in;
                pre_z = -16'sd16384;
            end
        end
    end

    always_comb begin
        x_shift = x_r >>> iter;
        y_shift = y_r >>> iter;
        atan_i  = atan_lut(iter);
        d_pos   = ~y_r[17];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            x_r        <= '0;
            y_r        <= '0;
            z_r        <= '0;
            iter       <= '0;
            zero_vec   <= 1'b0;
            bus.xprime <= '0;
            bus.theta  <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    bus.busy <= bus.start;
                    if (bus.start) begin
                        x_r      <= pre_x;
                        y_r      <= pre_y;
                        z_r      <= pre_z;
                        iter     <= '0;
                        zero_vec <= (bus.x == 16'sd0) && (bus.y == 16'sd0);
                        state    <= ITER;
                    end
                end
                ITER: begin
                    if (d_pos) begin
                        x_r <= x_r + y_shift;
                        y_r <= y_r - x_shift;
                        z_r <= z_r + atan_i;
                    end else begin
                        x_r <= x_r - y_shift;
                        y_r <= y_r + x_shift;
                        z_r <= z_r - atan_i;
                    end
                    iter <= iter + 4'd1;
                    if (iter == LAST_ITER) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Z wraps modulo 2^16, so +180 degrees reads as -32768.
                    bus.xprime <= zero_vec ? 17'd0 : x_r[16:0];
                    bus.theta  <= zero_vec ? 16'sd0 : z_r;
                    bus.done   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vectoring_cordic.sv
module tb_vectoring_cordic;

    localparam int N = 14;
    localparam int ATAN_TBL [14] = '{8192, 4836, 2555, 1297, 651, 326, 163,
                                     81, 41, 20, 10, 5, 3, 1};
    // truncating shifts leave a residual of a few LSB against the ideal math
    localparam int COARSE_TOL = 16;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    vectoring_cordic_if bus ();

    vectoring_cordic #(.ITERATIONS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp,
                              input int tol, input bit wrap16);
        int diff;
        logic signed [15:0] d16;
        d16  = 16'(obs - exp);
        diff = wrap16 ? int'(d16) : (obs - exp);
        if (diff < 0) diff = -diff;
        tests++;
        assert ((diff <= tol) === 1'b1) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Bit-true reference of the algorithm on plain integers.
    function automatic void model(input int xi, input int yi, output int xp, output int th);
        int X, Y, Z, Xn, Yn;
        logic signed [15:0] z16;
        if (xi >= 0) begin
            X = xi;  Y = yi;  Z = 0;
        end else if (yi >= 0) begin
            X = yi;  Y = -xi; Z = 16384;
        end else begin
            X = -yi; Y = xi;  Z = -16384;
        end
        for (int i = 0; i < N; i++) begin
            if (Y >= 0) begin
                Xn = X + (Y >>> i);
                Yn = Y - (X >>> i);
                Z  = Z + ATAN_TBL[i];
            end else begin
                Xn = X - (Y >>> i);
                Yn = Y + (X >>> i);
                Z  = Z - ATAN_TBL[i];
            end
            X = Xn;
            Y = Yn;
        end
        z16 = 16'(Z);
        if (xi == 0 && yi == 0) begin
            xp = 0;
            th = 0;
        end else begin
            xp = X;
            th = int'(z16);
        end
    endfunction

    task automatic run_conv(input int xi, input int yi, output int xp, output int th);
        int lat;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.x     = 16'(xi);
        bus.y     = 16'(yi);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        xp = int'(bus.xprime);
        th = int'(bus.theta);
        check("done_latency", lat, N + 1);
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
        check("busy_drop", bus.busy, 0);
    endtask

    task automatic conv_check(input string tag, input int xi, input int yi,
                              input int ideal_xp, input int ideal_th);
        int xp, th, mxp, mth;
        run_conv(xi, yi, xp, th);
        model(xi, yi, mxp, mth);
        check({tag, "_xprime"}, xp, mxp);
        check({tag, "_theta"}, th, mth);
        check_near({tag, "_xprime_ideal"}, xp, ideal_xp, COARSE_TOL, 1'b0);
        check_near({tag, "_theta_ideal"}, th, ideal_th, COARSE_TOL, 1'b1);
    endtask

    initial begin
        int ndone, lat, xp, th, mxp, mth, npulse;
        int pulse_cyc [3];

        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        reset     = 1'b0;

        #6;
        check("rst_xprime", bus.xprime, 0);
        check("rst_theta", bus.theta, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_done", bus.done, 0);

        conv_check("x1000_y0", 1000, 0, 1647, 0);
        conv_check("x0_y1000", 0, 1000, 1647, 16384);
        conv_check("xm1000_y0", -1000, 0, 1647, -32768);
        conv_check("xm707_ym707", -707, -707, 1646, -24576);
        conv_check("xmax_ymax", -32768, -32768, 76314, -24576);
        conv_check("zero_vec", 0, 0, 0, 0);

        // Start pulse in the middle of a conversion must be ignored.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.x     = 16'sd3000;
        bus.y     = 16'sd4000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        lat   = -1;
        xp    = 0;
        th    = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 4) begin
                bus.start = 1'b1;
                bus.x     = -16'sd5;
                bus.y     = 16'sd9;
            end
            if (n == 5) bus.start = 1'b0;
            if (n == 6) check("hold_xprime_mid_conv", bus.xprime, 0);
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    xp  = int'(bus.xprime);
                    th  = int'(bus.theta);
                end
            end
        end
        model(3000, 4000, mxp, mth);
        check("ignore_start_done_count", ndone, 1);
        check("ignore_start_latency", lat, N + 1);
        check("ignore_start_xprime", xp, mxp);
        check("ignore_start_theta", th, mth);
        check_near("ignore_start_theta_ideal", th, 9672, COARSE_TOL, 1'b1);
        check("hold_xprime_idle", bus.xprime, mxp);

        // Start held high: back-to-back conversions.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.x     = 16'sd1000;
        bus.y     = 16'sd0;
        npulse    = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (bus.done && npulse < 3) begin
                pulse_cyc[npulse] = n;
                npulse++;
            end
        end
        bus.start = 1'b0;
        check("held_start_pulses", npulse, 3);
        if (npulse == 3) begin
            check("held_start_period_1", pulse_cyc[1] - pulse_cyc[0], N + 2);
            check("held_start_period_2", pulse_cyc[2] - pulse_cyc[1], N + 2);
        end
        for (int n = 0; n < 40 && (bus.busy || bus.done); n++) begin
            @(posedge clk); #1;
        end
        check("held_start_drains", bus.busy, 0);
        model(1000, 0, mxp, mth);
        check("held_start_xprime", bus.xprime, mxp);

        // Asynchronous reset in the middle of a conversion.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.x     = 16'sd1000;
        bus.y     = 16'sd1000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_xprime", bus.xprime, 0);
        check("midrst_theta", bus.theta, 0);
        #2 reset = 1'b1;
        ndone = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) ndone++;
        end
        check("midrst_no_done_after", ndone, 0);
        conv_check("after_rst", 1000, 1000, 2329, 8192);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
